float_norm_round: RTL



---
 rtl/float_pkg.sv | 18 +
 rtl/float_naive_lzc.sv | 16 +
 rtl/float_norm_round.sv | 119 +++++++++++
 3 files changed

// File: rtl/float_pkg.sv
// float_pkg: shared FP32 constants and types for the adder's normalize/round datapath
package float_pkg;
   localparam int          BIAS    = 127;
   localparam int          EXP_MAX = 255;
   localparam logic [31:0] QNAN    = 32'h7FC00000;
   localparam logic [31:0] INF     = 32'h7F800000;
   typedef struct packed {
      logic        ovf;
      logic        hidden;
      logic [22:0] frac;
      logic        guard;
   } mant_t;
   typedef struct packed {
      logic ovfl;
      logic unfl;
      logic inex;
   } flags_t;
endpackage

// File: rtl/float_naive_lzc.sv
// float_naive_lzc: linear-scan leading zero counter, result = BIAS + STEP * zeros
module float_naive_lzc #(
   parameter int INPUT_WIDTH  = 26,
   parameter int OUTPUT_WIDTH = 5,
   parameter int STEP         = 1,
   parameter int BIAS         = 0
) (
   input  logic [INPUT_WIDTH-1:0]  i_data,
   output logic [OUTPUT_WIDTH-1:0] o_count
);
   always_comb begin
      o_count = OUTPUT_WIDTH'(BIAS + STEP * INPUT_WIDTH);
      for (int i = 0; i < INPUT_WIDTH; i++)
         if (i_data[i]) o_count = OUTPUT_WIDTH'(BIAS + STEP * (INPUT_WIDTH - 1 - i));
   end
endmodule

// File: rtl/float_norm_round.sv
// float_norm_round: 2-stage normalize then round-to-nearest-even and pack to binary32 (FTZ)
module float_norm_round
   import float_pkg::*;
#(
   parameter int EXP_W  = 10,
   parameter int MANT_W = 26
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic [MANT_W-1:0] in_mant,
   input  logic              in_sticky,
   input  logic              in_nan,
   input  logic              in_inf,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_result,
   output logic              out_of,
   output logic              out_uf,
   output logic              out_nx
);
   logic [4:0]       w_n;
   mant_t            w_m1, r_s1_m;
   logic [EXP_W-1:0] w_e1, r_s1_e1;
   logic             w_st1, w_zero, w_s1_adv, w_s2_adv;
   logic             r_s1_valid, r_s1_sign, r_s1_sticky, r_s1_nan, r_s1_inf, r_s1_zero;
   logic             w_up, w_unused;
   logic [23:0]      w_fr;
   logic [EXP_W:0]   w_e2;
   logic [31:0]      w_res, r_res;
   flags_t           w_fl, r_fl;
   logic             r_s2_valid;

   assign w_s2_adv = !r_s2_valid || out_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;
   assign in_ready = w_s1_adv;

   float_naive_lzc #(.INPUT_WIDTH(MANT_W), .OUTPUT_WIDTH(5), .STEP(1), .BIAS(0)) u_lzc (
      .i_data (in_mant),
      .o_count(w_n)
   );

   // leading one lands on the hidden bit; a right shift folds the old guard into sticky
   assign w_m1   = (w_n == 5'd0) ? mant_t'(in_mant >> 1) : mant_t'(in_mant << (w_n - 5'd1));
   assign w_st1  = in_sticky | (w_n == 5'd0 && in_mant[0]);
   assign w_e1   = in_exp + EXP_W'(1) - EXP_W'(w_n);
   assign w_zero = in_mant == '0 && !in_sticky;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_sign   <= 1'b0;
         r_s1_e1     <= '0;
         r_s1_m      <= '0;
         r_s1_sticky <= 1'b0;
         r_s1_nan    <= 1'b0;
         r_s1_inf    <= 1'b0;
         r_s1_zero   <= 1'b0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_sign   <= in_sign;
            r_s1_e1     <= w_e1;
            r_s1_m      <= w_m1;
            r_s1_sticky <= w_st1;
            r_s1_nan    <= in_nan;
            r_s1_inf    <= in_inf;
            r_s1_zero   <= w_zero;
         end
      end

   assign w_up     = r_s1_m.guard && (r_s1_sticky || r_s1_m.frac[0]);
   assign w_fr     = {1'b0, r_s1_m.frac} + 24'(w_up);
   assign w_e2     = {r_s1_e1[EXP_W-1], r_s1_e1} + (EXP_W+1)'(w_fr[23]);
   assign w_unused = r_s1_m.ovf ^ r_s1_m.hidden;

   always_comb begin
      w_res = {r_s1_sign, w_e2[7:0], w_fr[22:0]};
      w_fl  = '{ovfl: 1'b0, unfl: 1'b0, inex: r_s1_m.guard | r_s1_sticky};
      if (r_s1_nan) begin
         w_res = QNAN;
         w_fl  = '0;
      end else if (r_s1_inf) begin
         w_res = {r_s1_sign, INF[30:0]};
         w_fl  = '0;
      end else if (r_s1_zero) begin
         w_res = {r_s1_sign, 31'b0};
         w_fl  = '0;
      end else if (!w_e2[EXP_W] && w_e2 >= (EXP_W+1)'(EXP_MAX)) begin
         w_res = {r_s1_sign, INF[30:0]};
         w_fl  = '{ovfl: 1'b1, unfl: 1'b0, inex: 1'b1};
      end else if (w_e2[EXP_W] || w_e2 == '0) begin
         w_res = {r_s1_sign, 31'b0};
         w_fl  = '{ovfl: 1'b0, unfl: 1'b1, inex: 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_res      <= '0;
         r_fl       <= '0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_res <= w_res;
            r_fl  <= w_fl;
         end
      end

   assign out_valid  = r_s2_valid;
   assign out_result = r_res;
   assign out_of     = r_fl.ovfl;
   assign out_uf     = r_fl.unfl;
   assign out_nx     = r_fl.inex;
endmodule
